// File: rtl/spdif_encoder.sv
// spdif_encoder: S/PDIF (IEC 60958) biphase-mark transmitter with B/M/W preambles, even parity, 192-frame blocks.
// Latency: SPDIFout shows UI 0 one clk after the load cycle; every UI lasts HALF_DIV clks, a subframe 64*HALF_DIV.
// Backpressure: samples are taken only in the load cycle (dataReady); no data there sends a V=1 zero sample (underrun).
// Optional feature: define SPDIF_CSTATUS_EN to take C from the built-in channel-status block instead of chanIn.
module spdif_encoder #(
  parameter int HALF_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] dataIn,
  input  logic        validIn,
  input  logic        userIn,
  input  logic        chanIn,
  input  logic        dataValid,
  output logic        dataReady,
  output logic        chanSel,
  output logic [7:0]  frameCnt,
  output logic        blockStart,
  output logic        underrun,
  output logic        SPDIFout
);

  localparam int              DW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(HALF_DIV - 1);

  // Preamble UI patterns, UI 0 in the MSB, as sent when the line was 0 beforehand.
  localparam logic [7:0] PAT_B = 8'b1110_1000;
  localparam logic [7:0] PAT_M = 8'b1110_0010;
  localparam logic [7:0] PAT_W = 8'b1110_0100;

`ifdef SPDIF_CSTATUS_EN
  // Consumer, PCM, copy permitted (bit 2), 48 kHz (bits 27..24 = 4'b0010, i.e. bit 25).
  localparam logic [191:0] CSTAT = (192'd1 << 2) | (192'd1 << 25);
`endif

  typedef enum logic [1:0] {ST_RESET, ST_PREAMBLE, ST_DATA} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    ui_q, ui_d;
  logic          chan_q, chan_d;
  logic [7:0]    frame_q, frame_d;
  logic          line_q, line_d;
  logic [7:0]    pre_q, pre_d;     // preamble levels for this subframe, polarity already applied
  logic [31:0]   word_q, word_d;   // slot-indexed subframe bits; slots 0-3 unused

  logic          load;
  logic          ui_end;
  logic [7:0]    pat;
  logic [23:0]   aud;
  logic          v_bit;
  logic          u_bit;
  logic          c_bit;
  logic [26:0]   body;

  assign load   = rst_n && (div_q == '0) && (ui_q == 6'd0);
  assign ui_end = (div_q == DIV_LAST);

  assign pat    = chan_q ? PAT_W : ((frame_q == 8'd0) ? PAT_B : PAT_M);
  assign aud    = dataValid ? dataIn : 24'd0;
  assign v_bit  = dataValid ? validIn : 1'b1;
  assign u_bit  = dataValid & userIn;
`ifdef SPDIF_CSTATUS_EN
  // chanIn is read but has no effect: channel status comes from the constant block.
  assign c_bit  = CSTAT[frame_q] | (chanIn & 1'b0);
`else
  assign c_bit  = chanIn;
`endif
  assign body   = {c_bit, u_bit, v_bit, aud};

  assign dataReady  = load & dataValid;
  assign underrun   = load & ~dataValid;
  assign blockStart = load & ~chan_q & (frame_q == 8'd0);
  assign chanSel    = chan_q;
  assign frameCnt   = frame_q;
  assign SPDIFout   = line_q;

  // State register: everything returns to the start of a B subframe on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      div_q   <= '0;
      ui_q    <= 6'd0;
      chan_q  <= 1'b0;
      frame_q <= 8'd0;
      line_q  <= 1'b0;
      pre_q   <= 8'd0;
      word_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ui_q    <= ui_d;
      chan_q  <= chan_d;
      frame_q <= frame_d;
      line_q  <= line_d;
      pre_q   <= pre_d;
      word_q  <= word_d;
    end
  end

  // Next state: UI timing, sample capture and framing counters at load, BMC line level per UI, phase FSM.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ui_d    = ui_q;
    chan_d  = chan_q;
    frame_d = frame_q;
    line_d  = line_q;
    pre_d   = pre_q;
    word_d  = word_q;

    if (ui_end) begin
      div_d = '0;
      ui_d  = ui_q + 6'd1;
    end else begin
      div_d = div_q + DW'(1);
    end

    if (load) begin
      chan_d = ~chan_q;
      if (chan_q) begin
        frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
      end
      word_d = {^body, body, 4'b0000};
      pre_d  = pat ^ {8{line_q}};
    end

    // The line only moves on UI boundaries.
    if (div_q == '0) begin
      unique case (state_q)
        ST_RESET, ST_PREAMBLE: line_d = load ? (pat[7] ^ line_q) : pre_q[3'd7 - ui_q[2:0]];
        ST_DATA:               line_d = ui_q[0] ? (line_q ^ word_q[ui_q[5:1]]) : ~line_q;
        default:               line_d = line_q;
      endcase
    end

    unique case (state_q)
      ST_RESET:    state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (ui_end && ui_q == 6'd7)  state_d = ST_DATA;
      ST_DATA:     if (ui_end && ui_q == 6'd63) state_d = ST_PREAMBLE;
      default:     state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_spdif_encoder.sv
// tb_spdif_encoder: checks two encoders (HALF_DIV=4 with a directed sample table, HALF_DIV=1 over a full block wrap).
// The model builds each subframe's 64 UI levels from the line-coding rules and compares every output every cycle.
// Honours SPDIF_CSTATUS_EN for the expected C bit.
`timescale 1ns/1ps
module tb_spdif_encoder;
  localparam int HD0 = 4;
  localparam int HD1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [23:0] din_a, din_b;
  logic        v_a, u_a, c_a, dv_a;
  logic        v_b, u_b, c_b, dv_b;
  logic        rdy_a, csel_a, bst_a, und_a, line_a;
  logic        rdy_b, csel_b, bst_b, und_b, line_b;
  logic [7:0]  fcnt_a, fcnt_b;

  spdif_encoder #(.HALF_DIV(HD0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .dataIn(din_a), .validIn(v_a), .userIn(u_a), .chanIn(c_a),
    .dataValid(dv_a), .dataReady(rdy_a), .chanSel(csel_a), .frameCnt(fcnt_a),
    .blockStart(bst_a), .underrun(und_a), .SPDIFout(line_a)
  );

  spdif_encoder #(.HALF_DIV(HD1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .dataIn(din_b), .validIn(v_b), .userIn(u_b), .chanIn(c_b),
    .dataValid(dv_b), .dataReady(rdy_b), .chanSel(csel_b), .frameCnt(fcnt_b),
    .blockStart(bst_b), .underrun(und_b), .SPDIFout(line_b)
  );

  always #5 clk = ~clk;

  int          n = 0;            // posedges taken with rst_n high since the last reset
  int          run_id = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] lv [2];           // expected UI levels of the current subframe, UI 0 in bit 63
  logic [63:0] cap [2];          // observed UI levels of DUT A subframes 0 and 1
  int          rdy_pos[$];
  int          und_pos[$];
  int          blk_pos[$];
  int          fr_before = -1;
  int          fr_after = -1;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (n=%0d)", name, d, act, exp, n);
    end
  endtask

  // The 64 UI levels of one subframe, from the preamble table and the biphase-mark rule.
  function automatic logic [63:0] sf_levels(input logic prev, input int chan, input int frame,
                                            input logic [23:0] aud, input logic v, input logic u,
                                            input logic c);
    logic [7:0]  pat;
    logic [31:0] slot;
    logic        lvl;
    logic [63:0] r;
    if (chan == 1)       pat = 8'b11100100;
    else if (frame == 0) pat = 8'b11101000;
    else                 pat = 8'b11100010;
    slot       = '0;
    slot[27:4] = aud;
    slot[28]   = v;
    slot[29]   = u;
    slot[30]   = c;
    slot[31]   = ^slot[30:4];
    r = '0;
    for (int k = 0; k < 8; k++) r[63-k] = pat[7-k] ^ prev;
    lvl = r[56];
    for (int s = 4; s < 32; s++) begin
      lvl = ~lvl;
      r[63-2*s] = lvl;
      lvl = lvl ^ slot[s];
      r[62-2*s] = lvl;
    end
    return r;
  endfunction

  function automatic logic exp_c(input int frame, input logic cin_v);
`ifdef SPDIF_CSTATUS_EN
    return ((frame == 2) || (frame == 25)) | (cin_v & 1'b0);
`else
    return cin_v | (frame < 0);
`endif
  endfunction

  task automatic model_dut(input int d, input int hd, input logic a_line, input logic a_rdy,
                           input logic a_bst, input logic a_und, input logic a_csel,
                           input logic [7:0] a_fcnt, input logic [23:0] i_din, input logic i_v,
                           input logic i_u, input logic i_c, input logic i_dv);
    int   p, loads, ch, fr;
    logic is_load, e_line;
    p       = 64 * hd;
    is_load = ((n % p) == 0) && rst_n;
    loads   = (n == 0) ? 0 : (n - 1) / p + 1;
    ch      = loads % 2;
    fr      = (loads / 2) % 192;
    e_line  = (n == 0) ? 1'b0 : lv[d][63 - (((n - 1) / hd) % 64)];
    chk("line", d, a_line, e_line);
    chk("chanSel", d, a_csel, ch);
    chk("frameCnt", d, a_fcnt, fr);
    chk("dataReady", d, a_rdy, is_load && i_dv);
    chk("underrun", d, a_und, is_load && !i_dv);
    chk("blockStart", d, a_bst, is_load && ch == 0 && fr == 0);
    if (is_load)
      lv[d] = sf_levels(e_line, ch, fr, i_dv ? i_din : 24'd0, i_dv ? i_v : 1'b1, i_dv & i_u, exp_c(fr, i_c));
  endtask

  task automatic stim_a(input int k);
    case (k)
      0:       begin din_a = 24'h000000; v_a = 0; u_a = 0; c_a = 0; dv_a = 1; end
      1:       begin din_a = 24'h000001; v_a = 0; u_a = 0; c_a = 0; dv_a = 1; end
      2:       begin din_a = 24'h000000; v_a = 0; u_a = 1; c_a = 1; dv_a = 0; end
      3:       begin din_a = 24'h800000; v_a = 0; u_a = 1; c_a = 0; dv_a = 1; end
      4:       begin din_a = 24'hFFFFFF; v_a = 1; u_a = 0; c_a = 1; dv_a = 1; end
      5:       begin din_a = 24'hA5A5A5; v_a = 0; u_a = 1; c_a = 1; dv_a = 1; end
      6:       begin din_a = 24'h123456; v_a = 0; u_a = 1; c_a = 1; dv_a = 0; end
      7:       begin din_a = 24'h000000; v_a = 0; u_a = 0; c_a = 1; dv_a = 1; end
      default: begin
        din_a = 24'(k * 32'h00B41C3D);
        v_a   = k[0];
        u_a   = k[1];
        c_a   = k[2];
        dv_a  = (k % 11) != 5;
      end
    endcase
  endtask

  task automatic step(input logic rst_val);
    int ui_g;
    @(negedge clk);
    rst_n = rst_val;
    if ((n % (64 * HD0)) == 0) begin
      stim_a(n / (64 * HD0));
    end else begin
      din_a = 24'($urandom());
      v_a   = 1'($urandom_range(0, 1));
      u_a   = 1'($urandom_range(0, 1));
      c_a   = 1'($urandom_range(0, 1));
      dv_a  = 1'($urandom_range(0, 1));
    end
    #1;
    model_dut(0, HD0, line_a, rdy_a, bst_a, und_a, csel_a, fcnt_a, din_a, v_a, u_a, c_a, dv_a);
    model_dut(1, HD1, line_b, rdy_b, bst_b, und_b, csel_b, fcnt_b, din_b, v_b, u_b, c_b, dv_b);
    if (run_id == 0 && rst_val) begin
      if (n >= 1) begin
        ui_g = (n - 1) / HD0;
        if (((n - 1) % HD0) == 2 && ui_g < 128) cap[ui_g / 64] = {cap[ui_g / 64][62:0], line_a};
      end
      if (rdy_a && rdy_pos.size() < 2) rdy_pos.push_back(n);
      if (und_a && und_pos.size() < 1) und_pos.push_back(n);
      if (bst_b) blk_pos.push_back(n);
      if (n == 24511) fr_before = int'(fcnt_b);
      if (n == 24513) fr_after  = int'(fcnt_b);
    end
    if (rst_val) n++;
    else n = 0;
  endtask

  initial begin
    din_b = 24'd0; v_b = 1'b0; u_b = 1'b0; c_b = 1'b1; dv_b = 1'b1;
    din_a = 24'd0; v_a = 1'b0; u_a = 1'b0; c_a = 1'b0; dv_a = 1'b1;
    lv[0] = '0; lv[1] = '0; cap[0] = '0; cap[1] = '0;

    for (int i = 0; i < 10; i++) step(1'b0);
    // 385 DUT B subframes plus a margin: covers the 191->0 wrap and the second B preamble.
    for (int i = 0; i < 24776; i++) step(1'b1);

    chk("sf0_levels", 0, cap[0], 64'hE8CC_CCCC_CCCC_CCCC);
    chk("sf1_levels", 0, cap[1], 64'hE4B3_3333_3333_3332);
    chk("ready_count", 0, rdy_pos.size(), 2);
    chk("ready_first", 0, (rdy_pos.size() > 0) ? rdy_pos[0] : -1, 0);
    chk("ready_second", 0, (rdy_pos.size() > 1) ? rdy_pos[1] : -1, 256);
    chk("underrun_first", 0, (und_pos.size() > 0) ? und_pos[0] : -1, 512);
    chk("bpre_count", 1, blk_pos.size(), 2);
    chk("bpre_first", 1, (blk_pos.size() > 0) ? blk_pos[0] : -1, 0);
    chk("bpre_second", 1, (blk_pos.size() > 1) ? blk_pos[1] : -1, 24576);
    chk("frame_before_wrap", 1, fr_before, 191);
    chk("frame_after_wrap", 1, fr_after, 0);

    // Reset in the middle of a subframe, then restart from a B subframe.
    run_id = 1;
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 600; i++) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
